traffic_phase_ctrl: RTL

//  Parametrised two-road intersection controller with a pedestrian phase. Adds demand-based phase

---
 rtl/traffic_phase_ctrl_if.sv | 30 +++
 rtl/traffic_phase_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_ctrl_if.sv
// Detector inputs, emergency requests and lamp/status outputs of the
// intersection controller, bundled for the controller and its driver.
interface traffic_phase_ctrl_if #(
    parameter int CNT_W = 3,
    parameter int TW    = 5
);
    logic [CNT_W-1:0] main_num;
    logic [CNT_W-1:0] left_num;
    logic [CNT_W-1:0] sec_num;
    logic [CNT_W-1:0] p_num;
    logic             m_emergency;
    logic             s_emergency;
    logic [3:0]       m_LRYG;
    logic [2:0]       s_RYG;
    logic             ped;
    logic [3:0]       state;
    logic [TW-1:0]    sec_left;

    // Detector / request side: drives demand, watches the lamps.
    modport master (
        output main_num, left_num, sec_num, p_num, m_emergency, s_emergency,
        input  m_LRYG, s_RYG, ped, state, sec_left
    );

    // Controller side.
    modport slave (
        input  main_num, left_num, sec_num, p_num, m_emergency, s_emergency,
        output m_LRYG, s_RYG, ped, state, sec_left
    );
endinterface

// File: rtl/traffic_phase_ctrl.sv
// Two-road intersection controller with main-left arrow, pedestrian walk,
// demand-based skipping, main-green rest, all-red clearance and main/secondary
// emergency pre-emption. Phase timing comes from an on-chip seconds prescaler.
module traffic_phase_ctrl #(
    parameter int CLK_PER_SEC = 50_000_000,
    parameter int CNT_W       = 3,
    parameter int TW          = 5,
    parameter int T_MG        = 30,
    parameter int T_MY        = 3,
    parameter int T_ML        = 12,
    parameter int T_SG        = 18,
    parameter int T_SY        = 3,
    parameter int T_PG        = 18,
    parameter int T_AR        = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    traffic_phase_ctrl_if.slave  bus
);
    localparam int PW = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;

    localparam logic [3:0] INIT  = 4'd0;
    localparam logic [3:0] M_G   = 4'd1;
    localparam logic [3:0] M_Y   = 4'd2;
    localparam logic [3:0] M_L   = 4'd3;
    localparam logic [3:0] M_LY  = 4'd4;
    localparam logic [3:0] S_G   = 4'd5;
    localparam logic [3:0] S_Y   = 4'd6;
    localparam logic [3:0] P_G   = 4'd7;
    localparam logic [3:0] ALL_R = 4'd8;
    localparam logic [3:0] EMG_M = 4'd9;
    localparam logic [3:0] EMG_S = 4'd10;

    // Length in seconds of each timed phase; 0 marks the hold states.
    function automatic logic [TW-1:0] phase_len(input logic [3:0] st);
        case (st)
            M_G:       phase_len = TW'(T_MG);
            M_Y, M_LY: phase_len = TW'(T_MY);
            M_L:       phase_len = TW'(T_ML);
            S_G:       phase_len = TW'(T_SG);
            S_Y:       phase_len = TW'(T_SY);
            P_G:       phase_len = TW'(T_PG);
            ALL_R:     phase_len = TW'(T_AR);
            default:   phase_len = '0;
        endcase
    endfunction

    logic [3:0]    state_q, state_d;
    logic [3:0]    tgt_q, tgt_d;        // where ALL_R goes when it expires
    logic [PW-1:0] psc_q, psc_d;
    logic [TW-1:0] sec_q, sec_d;
    logic          rest_q, rest_d;      // M_G minimum served, waiting on demand
    logic          m_pend_q, m_pend_d;
    logic          s_pend_q, s_pend_d;

    logic [TW-1:0] phase_t;
    logic          tick, timed, expire, demand, m_act, s_act, go_ar;
    logic [3:0]    nxt_main, ar_tgt;

    // Main-road queue count is reported upstream only; it never steers sequencing.
    logic main_num_unused;
    assign main_num_unused = ^bus.main_num;

    // Timer status, demand decode and pending emergency requests.
    always_comb begin
        phase_t  = phase_len(state_q);
        timed    = (phase_t != '0);
        tick     = (psc_q == PW'(CLK_PER_SEC - 1));
        expire   = timed && tick && (sec_q == phase_t - TW'(1));
        demand   = (bus.left_num != '0) || (bus.sec_num != '0) || (bus.p_num != '0);
        m_act    = bus.m_emergency | m_pend_q;
        s_act    = bus.s_emergency | s_pend_q;
        nxt_main = (bus.sec_num != '0) ? S_G : ((bus.p_num != '0) ? P_G : M_G);
        // A request stays pending until its own emergency phase has been served.
        m_pend_d = bus.m_emergency | (m_pend_q & (state_q != EMG_M));
        s_pend_d = bus.s_emergency | (s_pend_q & (state_q != EMG_S));
    end

    // Phase sequencing, pre-emption and ALL_R target selection.
    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        go_ar   = 1'b0;
        ar_tgt  = M_G;
        case (state_q)
            INIT:  state_d = M_G;
            M_G: begin
                if (m_act)                             state_d = EMG_M;
                else if (s_act)                        state_d = M_Y;
                else if ((expire || rest_q) && demand) state_d = M_Y;
            end
            M_Y: if (expire) begin
                // The left arrow is skipped when an emergency is waiting.
                if (bus.left_num != '0 && !m_act && !s_act) state_d = M_L;
                else begin go_ar = 1'b1; ar_tgt = nxt_main; end
            end
            M_L:   if (s_act || expire) state_d = M_LY;
            M_LY:  if (expire) begin go_ar = 1'b1; ar_tgt = nxt_main; end
            S_G: begin
                if (m_act)       state_d = S_Y;
                else if (s_act)  state_d = EMG_S;
                else if (expire) state_d = S_Y;
            end
            S_Y:   if (expire) begin
                go_ar  = 1'b1;
                ar_tgt = (bus.p_num != '0) ? P_G : M_G;
            end
            P_G:   if (m_act || expire) begin go_ar = 1'b1; ar_tgt = M_G; end
            ALL_R: if (expire) state_d = m_act ? EMG_M : (s_act ? EMG_S : tgt_q);
            EMG_M: if (!bus.m_emergency) state_d = M_G;
            EMG_S: if (!bus.s_emergency || bus.m_emergency) state_d = S_Y;
            default: state_d = INIT;
        endcase
        if (go_ar) begin
            if (T_AR == 0) state_d = m_act ? EMG_M : (s_act ? EMG_S : ar_tgt);
            else begin
                state_d = ALL_R;
                tgt_d   = ar_tgt;
            end
        end
    end

    // Prescaler and seconds counter restart on every phase change; M_G saturates.
    always_comb begin
        psc_d  = tick ? '0 : psc_q + PW'(1);
        sec_d  = sec_q;
        rest_d = rest_q;
        if (tick && timed && sec_q != phase_t - TW'(1)) sec_d = sec_q + TW'(1);
        if (state_q == M_G && expire && !demand) rest_d = 1'b1;
        if (state_d != state_q) begin
            psc_d  = '0;
            sec_d  = '0;
            rest_d = 1'b0;
        end
    end

    // State and timer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= INIT;
            tgt_q    <= M_G;
            psc_q    <= '0;
            sec_q    <= '0;
            rest_q   <= 1'b0;
            m_pend_q <= 1'b0;
            s_pend_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            tgt_q    <= tgt_d;
            psc_q    <= psc_d;
            sec_q    <= sec_d;
            rest_q   <= rest_d;
            m_pend_q <= m_pend_d;
            s_pend_q <= s_pend_d;
        end
    end

    // Lamp decode straight from the state register.
    always_comb begin
        bus.m_LRYG = 4'b0100;
        bus.s_RYG  = 3'b100;
        bus.ped    = 1'b0;
        case (state_q)
            M_G, EMG_M: bus.m_LRYG = 4'b0001;
            M_Y:        bus.m_LRYG = 4'b0010;
            M_L:        bus.m_LRYG = 4'b1100;
            M_LY:       bus.m_LRYG = 4'b0110;
            S_G, EMG_S: bus.s_RYG  = 3'b001;
            S_Y:        bus.s_RYG  = 3'b010;
            P_G:        bus.ped    = 1'b1;
            default:    ;
        endcase
        bus.state    = state_q;
        bus.sec_left = phase_t - sec_q;
    end
endmodule
